// File: rtl/vram_access_unit_pkg.sv
// Shared HuC6270 definitions: register numbers, address increment encoding
// and the VRAM access FSM states.
package vram_access_unit_pkg;

  typedef logic [4:0] reg_sel_t;

  localparam reg_sel_t REG_MAWR = 5'h00;
  localparam reg_sel_t REG_MARR = 5'h01;
  localparam reg_sel_t REG_VRW  = 5'h02;
  localparam reg_sel_t REG_CR   = 5'h05;

  typedef enum logic [1:0] {
    INC_1   = 2'b00,
    INC_32  = 2'b01,
    INC_64  = 2'b10,
    INC_128 = 2'b11
  } inc_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } state_t;

  function automatic logic [15:0] addr_step(input inc_sel_t sel);
    case (sel)
      INC_1:   return 16'd1;
      INC_32:  return 16'd32;
      INC_64:  return 16'd64;
      default: return 16'd128;
    endcase
  endfunction

endpackage

// File: rtl/vram_access_unit_register.sv
// Generic enabled storage register with asynchronous active-low clear.
module Register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vram_access_unit.sv
// CPU data-port front end of the VDC: holds the VRAM address/data registers
// and sequences single-word VRAM reads and writes with a one-deep command queue.
module vram_access_unit
  import vram_access_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  reg_sel_t    reg_sel,
  input  logic        wr_lsb,
  input  logic        wr_msb,
  input  logic        rd_lsb,
  input  logic        rd_msb,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  output logic        vram_req,
  input  logic        vram_ack,
  input  logic [15:0] vram_rdata,
  output logic        BUSY_n,
  output logic        ovf
);

  logic [7:0]  latch_q;
  logic [15:0] mawr_q, marr_q, vrr_q, cr_q, wdata_q;
  logic [15:0] mawr_d, marr_d;
  logic [15:0] commit_word, step;
  logic [1:0]  state_q;
  logic [1:0]  pend_q, pend_d;
  logic        ovf_q;
  state_t      state, state_nxt;

  logic commit_mawr, commit_marr, commit_vwr, commit_cr;
  logic ack_write, ack_read, mawr_en, marr_en;
  logic new_valid, new_is_write;
  logic pend_valid_q, pend_is_write_q, pend_valid_nxt, pend_is_write_nxt;
  logic drop;
  logic cr_unused;

  assign commit_word = {DI, latch_q};
  assign commit_mawr = wr_msb && (reg_sel == REG_MAWR);
  assign commit_marr = wr_msb && (reg_sel == REG_MARR);
  assign commit_vwr  = wr_msb && (reg_sel == REG_VRW);
  assign commit_cr   = wr_msb && (reg_sel == REG_CR);

  assign state     = state_t'(state_q);
  assign step      = addr_step(inc_sel_t'(cr_q[12:11]));
  assign cr_unused = ^{cr_q[15:13], cr_q[10:0]};

  assign ack_write = (state == WRITE) && vram_ack;
  assign ack_read  = (state == READ) && vram_ack;

  // A CPU commit on the ack edge overrides the post-access increment.
  assign mawr_en = commit_mawr || ack_write;
  assign mawr_d  = commit_mawr ? commit_word : mawr_q + step;
  assign marr_en = commit_marr || ack_read;
  assign marr_d  = commit_marr ? commit_word : marr_q + step;

  assign new_valid    = commit_vwr || commit_marr || (rd_msb && (reg_sel == REG_VRW));
  assign new_is_write = commit_vwr;

  assign pend_valid_q    = pend_q[1];
  assign pend_is_write_q = pend_q[0];
  assign pend_d          = {pend_valid_nxt, pend_is_write_nxt};

  Register #(.WIDTH(8))  u_latch (.clock(clock), .rst_l(reset_n), .en(wr_lsb),     .d(DI),          .q(latch_q));
  Register #(.WIDTH(16)) u_cr    (.clock(clock), .rst_l(reset_n), .en(commit_cr),  .d(commit_word), .q(cr_q));
  Register #(.WIDTH(16)) u_wdata (.clock(clock), .rst_l(reset_n), .en(commit_vwr), .d(commit_word), .q(wdata_q));
  Register #(.WIDTH(16)) u_mawr  (.clock(clock), .rst_l(reset_n), .en(mawr_en),    .d(mawr_d),      .q(mawr_q));
  Register #(.WIDTH(16)) u_marr  (.clock(clock), .rst_l(reset_n), .en(marr_en),    .d(marr_d),      .q(marr_q));
  Register #(.WIDTH(16)) u_vrr   (.clock(clock), .rst_l(reset_n), .en(ack_read),   .d(vram_rdata),  .q(vrr_q));
  Register #(.WIDTH(2))  u_state (.clock(clock), .rst_l(reset_n), .en(1'b1),       .d(state_nxt),   .q(state_q));
  Register #(.WIDTH(2))  u_pend  (.clock(clock), .rst_l(reset_n), .en(1'b1),       .d(pend_d),      .q(pend_q));
  Register #(.WIDTH(1))  u_ovf   (.clock(clock), .rst_l(reset_n), .en(drop),       .d(1'b1),        .q(ovf_q));

  // IDLE serves the pending slot first; a command arriving that same cycle refills it.
  always_comb begin
    state_nxt         = state;
    pend_valid_nxt    = pend_valid_q;
    pend_is_write_nxt = pend_is_write_q;
    drop              = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid_q) begin
          state_nxt         = pend_is_write_q ? WRITE : READ;
          pend_valid_nxt    = new_valid;
          pend_is_write_nxt = new_is_write;
        end else if (new_valid) begin
          state_nxt = new_is_write ? WRITE : READ;
        end
      end
      default: begin
        if (vram_ack) begin
          state_nxt = IDLE;
        end
        if (new_valid) begin
          if (pend_valid_q) begin
            drop = 1'b1;
          end else begin
            pend_valid_nxt    = 1'b1;
            pend_is_write_nxt = new_is_write;
          end
        end
      end
    endcase
  end

  always_comb begin
    DO = 8'h00;
    if (reg_sel == REG_VRW) begin
      if (rd_lsb) begin
        DO = vrr_q[7:0];
      end else if (rd_msb) begin
        DO = vrr_q[15:8];
      end
    end
  end

  assign vram_req   = (state != IDLE);
  assign vram_we    = (state == WRITE);
  assign vram_addr  = (state == WRITE) ? mawr_q : marr_q;
  assign vram_wdata = wdata_q;
  assign BUSY_n     = (state == IDLE) && !pend_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vram_access_unit.sv
// Directed self-checking bench for vram_access_unit: write/read paths,
// increment and wrap, queue overflow, reset mid-access and ack collision.
module tb_vram_access_unit;
  import vram_access_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  reg_sel_t    reg_sel;
  logic        wr_lsb, wr_msb, rd_lsb, rd_msb;
  logic [7:0]  DI, DO;
  logic [15:0] vram_addr, vram_wdata, vram_rdata;
  logic        vram_we, vram_req, vram_ack;
  logic        BUSY_n, ovf;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int base_count;
  int busy_cnt;
  logic        held_ok;
  logic [15:0] last_waddr, last_wdata;

  vram_access_unit dut (
    .clock(clock), .reset_n(reset_n), .reg_sel(reg_sel),
    .wr_lsb(wr_lsb), .wr_msb(wr_msb), .rd_lsb(rd_lsb), .rd_msb(rd_msb),
    .DI(DI), .DO(DO), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_req(vram_req), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .BUSY_n(BUSY_n), .ovf(ovf)
  );

  always #5 clock = ~clock;

  // Record every completed VRAM write as seen on the bus.
  always @(posedge clock) begin
    if (reset_n && vram_req && vram_we && vram_ack) begin
      wr_count   = wr_count + 1;
      last_waddr = vram_addr;
      last_wdata = vram_wdata;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic write_reg(input reg_sel_t r, input logic [15:0] v);
    reg_sel = r;
    wr_lsb  = 1'b1;
    DI      = v[7:0];
    tick();
    wr_lsb  = 1'b0;
    wr_msb  = 1'b1;
    DI      = v[15:8];
    tick();
    wr_msb  = 1'b0;
    DI      = 8'h00;
  endtask

  task automatic ack_now(input logic [15:0] rdata);
    vram_rdata = rdata;
    vram_ack   = 1'b1;
    tick();
    vram_ack   = 1'b0;
    vram_rdata = 16'h0000;
  endtask

  initial begin
    reset_n = 1'b0; reg_sel = REG_MAWR;
    wr_lsb = 0; wr_msb = 0; rd_lsb = 0; rd_msb = 0;
    DI = 8'h00; vram_ack = 0; vram_rdata = 16'h0000;
    #2;
    check("reset_req", {15'd0, vram_req}, 16'd0);
    check("reset_we", {15'd0, vram_we}, 16'd0);
    check("reset_busy_n", {15'd0, BUSY_n}, 16'd1);
    check("reset_do", {8'd0, DO}, 16'h0000);
    check("reset_ovf", {15'd0, ovf}, 16'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Write path
    write_reg(REG_CR, 16'h0000);
    write_reg(REG_MAWR, 16'h1000);
    check("idle_after_addr_writes", {15'd0, BUSY_n}, 16'd1);
    write_reg(REG_VRW, 16'hBEEF);
    check("wr_req", {15'd0, vram_req}, 16'd1);
    check("wr_we", {15'd0, vram_we}, 16'd1);
    check("wr_addr", vram_addr, 16'h1000);
    check("wr_data", vram_wdata, 16'hBEEF);
    busy_cnt = BUSY_n ? 0 : 1;
    held_ok  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!BUSY_n) busy_cnt++;
      if (!(vram_req && vram_we && vram_addr == 16'h1000)) held_ok = 1'b0;
    end
    check("wr_request_held", {15'd0, held_ok}, 16'd1);
    ack_now(16'h0000);
    check("wr_busy_cycles", busy_cnt[15:0], 16'd4);
    check("wr_busy_released", {15'd0, BUSY_n}, 16'd1);
    check("wr_count", wr_count[15:0], 16'd1);
    check("wr_bus_addr", last_waddr, 16'h1000);
    check("wr_bus_data", last_wdata, 16'hBEEF);
    write_reg(REG_VRW, 16'h0001);
    check("mawr_plus1", vram_addr, 16'h1001);
    ack_now(16'h0000);

    // Read with +32 increment
    write_reg(REG_CR, 16'h0800);
    write_reg(REG_MARR, 16'h2000);
    check("rd_req", {15'd0, vram_req}, 16'd1);
    check("rd_we", {15'd0, vram_we}, 16'd0);
    check("rd_addr", vram_addr, 16'h2000);
    ack_now(16'h1234);
    reg_sel = REG_VRW;
    #1 check("do_no_pulse", {8'd0, DO}, 16'h0000);
    rd_lsb = 1'b1;
    #1 check("do_lsb", {8'd0, DO}, 16'h0034);
    rd_lsb = 1'b0;
    rd_msb = 1'b1;
    #1 check("do_msb", {8'd0, DO}, 16'h0012);
    tick();
    rd_msb = 1'b0;
    check("rd_msb_addr", vram_addr, 16'h2020);
    check("rd_msb_req", {15'd0, vram_req}, 16'd1);
    ack_now(16'h5678);

    // Unlisted register number is ignored
    write_reg(5'h03, 16'hFFFF);
    check("unlisted_reg_no_cmd", {15'd0, BUSY_n}, 16'd1);

    // Wrap-around with +128
    write_reg(REG_CR, 16'h1800);
    write_reg(REG_MAWR, 16'hFFC0);
    write_reg(REG_VRW, 16'h5555);
    check("wrap_first_addr", vram_addr, 16'hFFC0);
    ack_now(16'h0000);
    write_reg(REG_VRW, 16'h6666);
    check("wrap_addr", vram_addr, 16'h0040);
    ack_now(16'h0000);

    // Overflow: ack withheld over three commits
    write_reg(REG_CR, 16'h0000);
    write_reg(REG_MAWR, 16'h3000);
    base_count = wr_count;
    write_reg(REG_VRW, 16'h0A0A);
    write_reg(REG_VRW, 16'h0B0B);
    check("ovf_after_two", {15'd0, ovf}, 16'd0);
    write_reg(REG_VRW, 16'h0C0C);
    check("ovf_after_three", {15'd0, ovf}, 16'd1);
    check("ovf_first_addr", vram_addr, 16'h3000);
    ack_now(16'h0000);
    check("ovf_gap_req", {15'd0, vram_req}, 16'd0);
    check("ovf_gap_busy_n", {15'd0, BUSY_n}, 16'd0);
    tick();
    check("ovf_pending_req", {15'd0, vram_req}, 16'd1);
    check("ovf_pending_addr", vram_addr, 16'h3001);
    ack_now(16'h0000);
    tick();
    tick();
    check("ovf_write_total", 16'(wr_count - base_count), 16'd2);
    check("ovf_idle", {15'd0, BUSY_n}, 16'd1);
    check("ovf_sticky", {15'd0, ovf}, 16'd1);

    // Collision: CPU MAWR commit on the write-ack edge
    write_reg(REG_MAWR, 16'h4000);
    write_reg(REG_VRW, 16'h1111);
    check("coll_addr", vram_addr, 16'h4000);
    reg_sel = REG_MAWR;
    wr_lsb  = 1'b1;
    DI      = 8'h00;
    tick();
    wr_lsb   = 1'b0;
    wr_msb   = 1'b1;
    DI       = 8'h50;
    vram_ack = 1'b1;
    tick();
    wr_msb   = 1'b0;
    vram_ack = 1'b0;
    write_reg(REG_VRW, 16'h2222);
    check("coll_cpu_wins", vram_addr, 16'h5000);
    ack_now(16'h0000);

    // Reset mid-access
    write_reg(REG_VRW, 16'h3333);
    check("rst_pre_req", {15'd0, vram_req}, 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_req", {15'd0, vram_req}, 16'd0);
    check("rst_busy_n", {15'd0, BUSY_n}, 16'd1);
    check("rst_ovf", {15'd0, ovf}, 16'd0);
    tick();
    reset_n = 1'b1;
    reg_sel = REG_VRW;
    rd_lsb  = 1'b1;
    #1 check("rst_vrr_cleared", {8'd0, DO}, 16'h0000);
    rd_lsb = 1'b0;
    tick();
    write_reg(REG_VRW, 16'h7777);
    check("rst_mawr_zero", vram_addr, 16'h0000);
    ack_now(16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
